tx_frame_scheduler: RTL and testbench

//  Sequences the XGMII TX frame generator on port 0: ARP resolution of the gateway MAC,

---
 rtl/measure_pkg.sv | 29 ++
 rtl/tx_frame_scheduler_if.sv | 16 +
 rtl/tx_rate_meter.sv | 58 +++++
 rtl/tx_frame_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/measure_pkg.sv
// rtl/measure_pkg.sv - shared encodings and helpers for the TX/RX measurement blocks
// Contents: scheduler state encoding, generator frame-kind codes, broadcast MAC,
//   FCS length and a saturating 32-bit adder.
package measure_pkg;

    typedef enum logic [2:0] {
        TX_IDLE        = 3'd0,
        TX_REQ_ARP     = 3'd1,
        TX_WAIT_ARPREP = 3'd2,
        TX_SEND        = 3'd3,
        TX_GAP         = 3'd4
    } tx_state_e;

    typedef logic [1:0] gen_kind_t;

    localparam gen_kind_t   KIND_ARP  = 2'd0;
    localparam gen_kind_t   KIND_V4   = 2'd1;
    localparam gen_kind_t   KIND_V6   = 2'd2;
    localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;
    localparam logic [15:0] FCS_LEN   = 16'd4;

    // Rate counters pin at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hffff_ffff : sum[31:0];
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// rtl/tx_frame_scheduler_if.sv - scheduler <-> XGMII frame generator handshake
// Signals: gen_start (frame start pulse), gen_kind (ARP/V4/V6, held for the frame),
//   tx_dst_mac (destination MAC), gen_done (terminate-word pulse from the generator).
// Modports: master = scheduler side, slave = generator side.
interface tx_frame_scheduler_if;
    import measure_pkg::*;

    logic        gen_start;
    gen_kind_t   gen_kind;
    logic [47:0] tx_dst_mac;
    logic        gen_done;

    modport master (output gen_start, output gen_kind, output tx_dst_mac, input gen_done);
    modport slave  (input gen_start, input gen_kind, input tx_dst_mac, output gen_done);

endinterface

// File: rtl/tx_rate_meter.sv
// rtl/tx_rate_meter.sv - per-second event/byte meter with saturating accumulators
// Ports: sys_clk, sys_rst (async, active-high); sec_oneshot closes a window;
//   cnt_valid/cnt_bytes add one event of cnt_bytes bytes; pps/bytes_per_sec hold
//   the totals of the last complete window.
module tx_rate_meter
    import measure_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sec_oneshot,
    input  logic        cnt_valid,
    input  logic [31:0] cnt_bytes,
    output logic [31:0] pps,
    output logic [31:0] bytes_per_sec
);

    logic [31:0] pps_acc_q, pps_acc_d;
    logic [31:0] byte_acc_q, byte_acc_d;
    logic [31:0] pps_q, pps_d;
    logic [31:0] bps_q, bps_d;
    logic [31:0] pps_inc, byte_inc;

    always_comb begin
        pps_inc  = cnt_valid ? 32'd1 : 32'd0;
        byte_inc = cnt_valid ? cnt_bytes : 32'd0;
        pps_d    = pps_q;
        bps_d    = bps_q;
        if (sec_oneshot) begin
            // Publish the closed window and seed the new one with this cycle's
            // event so a frame ending on the boundary is not lost.
            pps_d      = pps_acc_q;
            bps_d      = byte_acc_q;
            pps_acc_d  = pps_inc;
            byte_acc_d = byte_inc;
        end else begin
            pps_acc_d  = sat_add32(pps_acc_q, pps_inc);
            byte_acc_d = sat_add32(byte_acc_q, byte_inc);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pps_acc_q  <= 32'd0;
            byte_acc_q <= 32'd0;
            pps_q      <= 32'd0;
            bps_q      <= 32'd0;
        end else begin
            pps_acc_q  <= pps_acc_d;
            byte_acc_q <= byte_acc_d;
            pps_q      <= pps_d;
            bps_q      <= bps_d;
        end
    end

    assign pps           = pps_q;
    assign bytes_per_sec = bps_q;

endmodule

// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - TX port sequencer: ARP resolution, then gapped test frames
// Ports: sys_clk, sys_rst (async, active-high); sec_oneshot; tx_enable, tx_ipv6,
//   tx_req_arp, tx_frame_len, tx_inter_frame_gap (user registers); arp_reply_valid,
//   arp_reply_mac (RX side); gen (generator handshake, master); tx_pps, tx_throughput
//   (last-second rates); arp_fail (sticky until tx_enable drops).
module tx_frame_scheduler
    import measure_pkg::*;
#(
    parameter logic [31:0] ARP_TIMEOUT = 32'd156250,
    parameter logic [3:0]  ARP_RETRY   = 4'd3,
    parameter logic [31:0] MIN_GAP     = 32'd2
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        sec_oneshot,
    input  logic                        tx_enable,
    input  logic                        tx_ipv6,
    input  logic                        tx_req_arp,
    input  logic [15:0]                 tx_frame_len,
    input  logic [31:0]                 tx_inter_frame_gap,
    input  logic                        arp_reply_valid,
    input  logic [47:0]                 arp_reply_mac,
    tx_frame_scheduler_if.master        gen,
    output logic [31:0]                 tx_pps,
    output logic [31:0]                 tx_throughput,
    output logic                        arp_fail
);

    tx_state_e   state_q, state_d;
    logic        open_q, open_d;          // a frame is in flight at the generator
    gen_kind_t   kind_q, kind_d;
    logic [15:0] len_q, len_d;
    logic [47:0] mac_q, mac_d;
    logic        resolved_q, resolved_d;
    logic        arp_fail_q, arp_fail_d;
    logic [3:0]  retry_q, retry_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] gap_q, gap_d;

    logic        gen_start;
    gen_kind_t   gen_kind;
    logic        count_valid;
    logic [31:0] gap_load;
    logic [3:0]  retry_inc;
    logic [31:0] frame_bytes;

    assign gap_load    = (tx_inter_frame_gap < MIN_GAP) ? MIN_GAP : tx_inter_frame_gap;
    assign retry_inc   = retry_q + 4'd1;
    assign frame_bytes = {16'd0, len_q} + {16'd0, FCS_LEN};

    always_comb begin
        state_d     = state_q;
        open_d      = open_q;
        kind_d      = kind_q;
        len_d       = len_q;
        mac_d       = mac_q;
        resolved_d  = resolved_q;
        arp_fail_d  = arp_fail_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        gen_start   = 1'b0;
        gen_kind    = kind_q;
        count_valid = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (tx_enable) begin
                    if (tx_req_arp && !resolved_q) begin
                        // After a failed resolution stay parked until tx_enable drops.
                        if (!arp_fail_q) begin
                            state_d = TX_REQ_ARP;
                            retry_d = 4'd0;
                            mac_d   = BCAST_MAC;
                        end
                    end else begin
                        state_d = TX_SEND;
                    end
                end
            end

            TX_REQ_ARP: begin
                if (!open_q) begin
                    gen_start = 1'b1;
                    kind_d    = KIND_ARP;
                    gen_kind  = KIND_ARP;
                    open_d    = 1'b1;
                end else if (gen.gen_done) begin
                    open_d  = 1'b0;
                    timer_d = 32'd0;
                    state_d = TX_WAIT_ARPREP;
                end
            end

            TX_WAIT_ARPREP: begin
                // A reply on the timeout cycle is still accepted.
                if (arp_reply_valid) begin
                    mac_d      = arp_reply_mac;
                    resolved_d = 1'b1;
                    if (tx_enable) begin
                        gap_d   = gap_load - 32'd1;
                        state_d = TX_GAP;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else if (timer_q == ARP_TIMEOUT - 32'd1) begin
                    retry_d = retry_inc;
                    if (!tx_enable) begin
                        state_d = TX_IDLE;
                    end else if (retry_inc < ARP_RETRY) begin
                        mac_d   = BCAST_MAC;
                        state_d = TX_REQ_ARP;
                    end else begin
                        arp_fail_d = 1'b1;
                        state_d    = TX_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            TX_SEND: begin
                if (!open_q) begin
                    gen_start = 1'b1;
                    kind_d    = tx_ipv6 ? KIND_V6 : KIND_V4;
                    gen_kind  = kind_d;
                    len_d     = tx_frame_len;
                    open_d    = 1'b1;
                end else if (gen.gen_done) begin
                    open_d      = 1'b0;
                    count_valid = 1'b1;
                    gap_d       = gap_load - 32'd1;
                    state_d     = TX_GAP;
                end
            end

            TX_GAP: begin
                if (gap_q == 32'd0) begin
                    state_d = tx_enable ? TX_SEND : TX_IDLE;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end

            default: state_d = TX_IDLE;
        endcase

        if (!tx_enable) begin
            resolved_d = 1'b0;
            arp_fail_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= TX_IDLE;
            open_q     <= 1'b0;
            kind_q     <= KIND_ARP;
            len_q      <= 16'd0;
            mac_q      <= BCAST_MAC;
            resolved_q <= 1'b0;
            arp_fail_q <= 1'b0;
            retry_q    <= 4'd0;
            timer_q    <= 32'd0;
            gap_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            open_q     <= open_d;
            kind_q     <= kind_d;
            len_q      <= len_d;
            mac_q      <= mac_d;
            resolved_q <= resolved_d;
            arp_fail_q <= arp_fail_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
        end
    end

    tx_rate_meter u_rate_meter (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .sec_oneshot   (sec_oneshot),
        .cnt_valid     (count_valid),
        .cnt_bytes     (frame_bytes),
        .pps           (tx_pps),
        .bytes_per_sec (tx_throughput)
    );

    assign gen.gen_start  = gen_start;
    assign gen.gen_kind   = gen_kind;
    assign gen.tx_dst_mac = mac_q;
    assign arp_fail       = arp_fail_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb/tb_tx_frame_scheduler.sv - self-checking bench for tx_frame_scheduler
module tb_tx_frame_scheduler;
    import measure_pkg::*;

    logic        sys_clk;
    logic        sys_rst;
    logic        sec_oneshot;
    logic        tx_enable;
    logic        tx_ipv6;
    logic        tx_req_arp;
    logic [15:0] tx_frame_len;
    logic [31:0] tx_inter_frame_gap;
    logic        arp_reply_valid;
    logic [47:0] arp_reply_mac;
    logic [31:0] tx_pps;
    logic [31:0] tx_throughput;
    logic        arp_fail;

    tx_frame_scheduler_if gen_if ();

    tx_frame_scheduler #(
        .ARP_TIMEOUT (32'd100),
        .ARP_RETRY   (4'd3),
        .MIN_GAP     (32'd2)
    ) dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .sec_oneshot        (sec_oneshot),
        .tx_enable          (tx_enable),
        .tx_ipv6            (tx_ipv6),
        .tx_req_arp         (tx_req_arp),
        .tx_frame_len       (tx_frame_len),
        .tx_inter_frame_gap (tx_inter_frame_gap),
        .arp_reply_valid    (arp_reply_valid),
        .arp_reply_mac      (arp_reply_mac),
        .gen                (gen_if),
        .tx_pps             (tx_pps),
        .tx_throughput      (tx_throughput),
        .arp_fail           (arp_fail)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic        ipv6;
        logic [15:0] len;
        logic [31:0] gap;
        int          fc;
        int          exp_spacing;
        logic [1:0]  exp_kind;
    } vec_t;

    vec_t vecs [6];

    int n_vec = 0;
    int n_err = 0;

    // generator / ARP-responder model state
    int          cyc = 0;
    int          done_cnt = 0;
    int          reply_cnt = 0;
    int          frame_cycles = 8;
    int          reply_delay = 50;
    bit          auto_reply = 1'b0;
    int          n_starts = 0;
    int          n_arp = 0;
    int          n_data = 0;
    int          n_done = 0;
    int          sec_at_done = -1;
    int          last_start = 0;
    int          prev_start = 0;
    logic [1:0]  last_kind = KIND_ARP;
    logic [47:0] last_mac = BCAST_MAC;
    logic [47:0] reply_mac_val = 48'h0037_7600_0101;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs at the negedge, then drive this cycle's inputs.
    task automatic tick();
        @(negedge sys_clk);
        cyc++;
        gen_if.gen_done = 1'b0;
        arp_reply_valid = 1'b0;
        sec_oneshot     = 1'b0;
        if (reply_cnt > 0) begin
            reply_cnt--;
            if (reply_cnt == 0) begin
                arp_reply_valid = 1'b1;
                arp_reply_mac   = reply_mac_val;
            end
        end
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                gen_if.gen_done = 1'b1;
                if (last_kind == KIND_ARP) begin
                    if (auto_reply) reply_cnt = reply_delay;
                end else begin
                    n_done++;
                    if (n_done == sec_at_done) sec_oneshot = 1'b1;
                end
            end
        end
        if (gen_if.gen_start) begin
            prev_start = last_start;
            last_start = cyc;
            n_starts++;
            last_kind = gen_if.gen_kind;
            last_mac  = gen_if.tx_dst_mac;
            if (gen_if.gen_kind == KIND_ARP) n_arp++;
            else n_data++;
            done_cnt = frame_cycles;
        end
    endtask

    task automatic clear_counts();
        n_starts = 0;
        n_arp = 0;
        n_data = 0;
        last_start = 0;
        prev_start = 0;
    endtask

    task automatic drain();
        tx_enable = 1'b0;
        repeat (250) tick();
    endtask

    task automatic wait_starts(input int target, input int bound, input string name);
        int k;
        k = 0;
        while (n_starts < target && k < bound) begin
            tick();
            k++;
        end
        if (n_starts < target) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout, got %0d gen_start pulses, expected %0d", name, n_starts, target);
        end
    endtask

    task automatic assert_reset_now();
        sys_rst = 1'b1;
        done_cnt = 0;
        reply_cnt = 0;
        gen_if.gen_done = 1'b0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gen_start"}, 64'(gen_if.gen_start), 64'(0));
        check({tag, "_gen_kind"}, 64'(gen_if.gen_kind), 64'(KIND_ARP));
        check({tag, "_dst_mac"}, 64'(gen_if.tx_dst_mac), 64'(BCAST_MAC));
        check({tag, "_tx_pps"}, 64'(tx_pps), 64'(0));
        check({tag, "_tx_thr"}, 64'(tx_throughput), 64'(0));
        check({tag, "_arp_fail"}, 64'(arp_fail), 64'(0));
    endtask

    initial begin
        // spacing = frame cycles + max(gap, 2) + 1
        vecs[0] = '{1'b0, 16'd64,   32'd10,  8,  19, KIND_V4};
        vecs[1] = '{1'b1, 16'd128,  32'd5,   4,  10, KIND_V6};
        vecs[2] = '{1'b0, 16'd1500, 32'd0,   20, 23, KIND_V4};
        vecs[3] = '{1'b1, 16'd64,   32'd1,   3,  6,  KIND_V6};
        vecs[4] = '{1'b0, 16'd64,   32'd2,   8,  11, KIND_V4};
        vecs[5] = '{1'b1, 16'd9000, 32'd100, 1,  102, KIND_V6};

        sys_rst            = 1'b1;
        sec_oneshot        = 1'b0;
        tx_enable          = 1'b0;
        tx_ipv6            = 1'b0;
        tx_req_arp         = 1'b0;
        tx_frame_len       = 16'd64;
        tx_inter_frame_gap = 32'd10;
        arp_reply_valid    = 1'b0;
        arp_reply_mac      = 48'd0;
        gen_if.gen_done    = 1'b0;

        repeat (3) tick();
        check_reset_outputs("por");
        sys_rst = 1'b0;
        repeat (3) tick();

        // table: back-to-back data frames
        for (int i = 0; i < 6; i++) begin
            drain();
            tx_ipv6            = vecs[i].ipv6;
            tx_frame_len       = vecs[i].len;
            tx_inter_frame_gap = vecs[i].gap;
            frame_cycles       = vecs[i].fc;
            tx_req_arp         = 1'b0;
            clear_counts();
            tx_enable = 1'b1;
            wait_starts(2, 600, $sformatf("vec%0d_starts", i));
            check($sformatf("vec%0d_spacing", i), 64'(last_start - prev_start), 64'(vecs[i].exp_spacing));
            check($sformatf("vec%0d_kind", i), 64'(last_kind), 64'(vecs[i].exp_kind));
            check($sformatf("vec%0d_mac", i), 64'(last_mac), 64'(BCAST_MAC));
        end

        // gap 0 clamped; tx_ipv6 change mid-frame only applies at the next start
        drain();
        tx_ipv6 = 1'b0;
        tx_inter_frame_gap = 32'd0;
        frame_cycles = 8;
        clear_counts();
        tx_enable = 1'b1;
        wait_starts(1, 50, "kind_first");
        check("kind_first_v4", 64'(last_kind), 64'(KIND_V4));
        repeat (3) tick();
        tx_ipv6 = 1'b1;
        tick();
        check("kind_held_mid_frame", 64'(gen_if.gen_kind), 64'(KIND_V4));
        wait_starts(2, 50, "kind_second");
        check("kind_second_v6", 64'(last_kind), 64'(KIND_V6));
        check("clamp_spacing", 64'(last_start - prev_start), 64'(11));

        // ARP resolution, reply 50 cycles after the ARP frame ends
        drain();
        tx_ipv6 = 1'b0;
        tx_inter_frame_gap = 32'd10;
        tx_req_arp = 1'b1;
        auto_reply = 1'b1;
        reply_mac_val = 48'h0037_7600_0101;
        clear_counts();
        tx_enable = 1'b1;
        wait_starts(2, 300, "arp_ok");
        check("arp_ok_n_arp", 64'(n_arp), 64'(1));
        check("arp_ok_kind", 64'(last_kind), 64'(KIND_V4));
        check("arp_ok_mac", 64'(last_mac), 64'(48'h0037_7600_0101));
        check("arp_ok_spacing", 64'(last_start - prev_start), 64'(69));
        drain();
        check("mac_kept_after_disable", 64'(gen_if.tx_dst_mac), 64'(48'h0037_7600_0101));

        // ARP with no reply: three attempts then arp_fail
        auto_reply = 1'b0;
        clear_counts();
        tx_enable = 1'b1;
        wait_starts(3, 600, "arp_fail_starts");
        check("arp_retry_spacing", 64'(last_start - prev_start), 64'(109));
        check("arp_retry_mac", 64'(last_mac), 64'(BCAST_MAC));
        repeat (300) tick();
        check("arp_fail_n_arp", 64'(n_arp), 64'(3));
        check("arp_fail_n_data", 64'(n_data), 64'(0));
        check("arp_fail_set", 64'(arp_fail), 64'(1));
        tx_enable = 1'b0;
        tick();
        check("arp_fail_cleared", 64'(arp_fail), 64'(0));

        // rate window closing on the 11th frame's gen_done
        tx_req_arp = 1'b0;
        tx_frame_len = 16'd64;
        drain();
        sec_oneshot = 1'b1;
        tick();
        n_done = 0;
        sec_at_done = 11;
        clear_counts();
        tx_enable = 1'b1;
        for (int k = 0; k < 1000 && n_done < 11; k++) tick();
        tx_enable = 1'b0;
        check("rate_reached_11", 64'(n_done), 64'(11));
        tick();
        check("rate_pps", 64'(tx_pps), 64'(10));
        check("rate_thr", 64'(tx_throughput), 64'(680));
        sec_at_done = -1;
        repeat (50) tick();
        check("rate_no_extra_frame", 64'(n_starts), 64'(11));
        sec_oneshot = 1'b1;
        tick();
        tick();
        check("rate_next_pps", 64'(tx_pps), 64'(1));
        check("rate_next_thr", 64'(tx_throughput), 64'(68));

        // reset in the gen_start cycle of a data frame after ARP resolution
        drain();
        tx_req_arp = 1'b1;
        auto_reply = 1'b1;
        reply_mac_val = 48'h0037_7600_0202;
        clear_counts();
        tx_enable = 1'b1;
        wait_starts(2, 300, "rst_send_starts");
        check("rst_send_mac_before", 64'(gen_if.tx_dst_mac), 64'(48'h0037_7600_0202));
        check("rst_send_start_before", 64'(gen_if.gen_start), 64'(1));
        assert_reset_now();
        check_reset_outputs("rst_send");
        tick();
        tick();

        // reset while waiting for an ARP reply
        auto_reply = 1'b0;
        clear_counts();
        sys_rst = 1'b0;
        wait_starts(1, 20, "rst_wait_start");
        check("rst_wait_first_arp", 64'(last_kind), 64'(KIND_ARP));
        repeat (20) tick();
        assert_reset_now();
        check_reset_outputs("rst_wait");
        tx_enable = 1'b0;
        tick();
        sys_rst = 1'b0;
        tick();

        // tx_enable dropped mid-frame: frame completes, no further starts
        tx_req_arp = 1'b0;
        drain();
        clear_counts();
        n_done = 0;
        tx_enable = 1'b1;
        wait_starts(1, 20, "stop_start");
        repeat (2) tick();
        tx_enable = 1'b0;
        repeat (250) tick();
        check("stop_one_start", 64'(n_starts), 64'(1));
        check("stop_frame_done", 64'(n_done), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
